// File: rtl/time_set_controller_if.sv
// time_set_controller_if: button, live-time and set-value bundle between the UI controller and the clock/date handlers.
interface time_set_controller_if;
  logic        btn_mode, btn_next, btn_inc, btn_dec;
  logic [7:0]  cur_sec, cur_min, cur_hour, cur_day, cur_month;
  logic [15:0] cur_year;
  logic [7:0]  input_sec, input_min, input_hour, input_day, input_month;
  logic [15:0] input_year;
  logic        set_time, set_date, editing;
  logic [2:0]  edit_field;
  modport master (
    output btn_mode, btn_next, btn_inc, btn_dec,
    output cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
    input  input_sec, input_min, input_hour, input_day, input_month, input_year,
    input  set_time, set_date, editing, edit_field
  );
  modport slave (
    input  btn_mode, btn_next, btn_inc, btn_dec,
    input  cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
    output input_sec, input_min, input_hour, input_day, input_month, input_year,
    output set_time, set_date, editing, edit_field
  );
endinterface

// File: rtl/time_set_controller.sv
// time_set_controller: button-driven time/date edit FSM producing set_time/set_date load strobes.
// Optional edit-inactivity timeout is enabled by defining SET_TIMEOUT_EN.
module time_set_controller #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd30
) (
  input logic clk,
  input logic reset,
  time_set_controller_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT_TIME,
    EDIT_DAY, EDIT_MONTH, EDIT_YEAR, COMMIT_DATE
  } state_e;
  state_e      state_q, state_d;
  logic [7:0]  hour_q, hour_d, min_q, min_d, sec_q, sec_d, day_q, day_d, month_q, month_d;
  logic [15:0] year_q, year_d;
  logic        set_time_q, set_date_q;
  logic        leap, pulse, up, step, in_edit;
  logic [7:0]  dmax, day_c;
  logic [2:0]  field;
`ifdef SET_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
  assign field = state_q == EDIT_HOUR  ? 3'd1 :
                 state_q == EDIT_MIN   ? 3'd2 :
                 state_q == EDIT_SEC   ? 3'd3 :
                 state_q == EDIT_DAY   ? 3'd4 :
                 state_q == EDIT_MONTH ? 3'd5 :
                 state_q == EDIT_YEAR  ? 3'd6 : 3'd0;
  assign in_edit = field != 3'd0;
  assign leap  = (year_q % 16'd4 == 16'd0 && year_q % 16'd100 != 16'd0) || year_q % 16'd400 == 16'd0;
  assign dmax  = month_q inside {8'd4, 8'd6, 8'd9, 8'd11} ? 8'd30 :
                 month_q == 8'd2 ? (leap ? 8'd29 : 8'd28) : 8'd31;
  // a day left over from a longer month is clamped rather than rejected
  assign day_c = day_q > dmax ? dmax : day_q;
  assign pulse = bus.btn_mode | bus.btn_next | bus.btn_inc | bus.btn_dec;
  assign up    = bus.btn_inc;
  assign step  = bus.btn_inc ^ bus.btn_dec;
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
`ifdef SET_TIMEOUT_EN
    cnt_d   = (in_edit && !pulse) ? cnt_q + 16'd1 : 16'd0;
`endif
    case (state_q)
      IDLE: if (bus.btn_mode) begin
        state_d = EDIT_HOUR;
        hour_d  = bus.cur_hour;
        min_d   = bus.cur_min;
        sec_d   = bus.cur_sec;
        day_d   = bus.cur_day;
        month_d = bus.cur_month;
        year_d  = bus.cur_year;
      end
      COMMIT_TIME: state_d = EDIT_DAY;
      COMMIT_DATE: state_d = IDLE;
      default: if (bus.btn_mode) state_d = IDLE;
      else if (bus.btn_next) state_d = state_e'(state_q + 4'd1);
      else if (step) case (state_q)
        EDIT_HOUR:  hour_d  = up ? (hour_q >= 8'd23 ? 8'd0 : hour_q + 8'd1) : (hour_q == 8'd0 ? 8'd23 : hour_q - 8'd1);
        EDIT_MIN:   min_d   = up ? (min_q >= 8'd59 ? 8'd0 : min_q + 8'd1) : (min_q == 8'd0 ? 8'd59 : min_q - 8'd1);
        EDIT_SEC:   sec_d   = up ? (sec_q >= 8'd59 ? 8'd0 : sec_q + 8'd1) : (sec_q == 8'd0 ? 8'd59 : sec_q - 8'd1);
        EDIT_DAY:   day_d   = up ? (day_c >= dmax ? 8'd1 : day_c + 8'd1) : (day_c <= 8'd1 ? dmax : day_c - 8'd1);
        EDIT_MONTH: month_d = up ? (month_q >= 8'd12 ? 8'd1 : month_q + 8'd1) : (month_q <= 8'd1 ? 8'd12 : month_q - 8'd1);
        default:    year_d  = up ? (year_q >= 16'd2099 ? 16'd2000 : year_q + 16'd1) : (year_q <= 16'd2000 ? 16'd2099 : year_q - 16'd1);
      endcase
    endcase
`ifdef SET_TIMEOUT_EN
    if (cnt_d >= TIMEOUT_CYCLES) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hour_q     <= 8'd0;
      min_q      <= 8'd0;
      sec_q      <= 8'd0;
      day_q      <= 8'd1;
      month_q    <= 8'd1;
      year_q     <= 16'd2020;
      set_time_q <= 1'b0;
      set_date_q <= 1'b0;
`ifdef SET_TIMEOUT_EN
      cnt_q      <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      day_q      <= day_d;
      month_q    <= month_d;
      year_q     <= year_d;
      set_time_q <= state_d == COMMIT_TIME;
      set_date_q <= state_d == COMMIT_DATE;
`ifdef SET_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end
  assign bus.input_sec   = sec_q;
  assign bus.input_min   = min_q;
  assign bus.input_hour  = hour_q;
  assign bus.input_day   = day_c;
  assign bus.input_month = month_q;
  assign bus.input_year  = year_q;
  assign bus.set_time    = set_time_q;
  assign bus.set_date    = set_date_q;
  assign bus.editing     = state_q != IDLE;
  assign bus.edit_field  = field;
endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd30, edit-inactivity limit in clk cycles (used only with SET_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports btn_mode, btn_next, btn_inc, btn_dec  input  1 each  debounced single-cycle button pulses.
REQ-005 SHALL have ports cur_sec, cur_min, cur_hour, cur_day, cur_month  input  8 each, and cur_year  input  16  live 24-hour time/date from the clock and date handlers.
REQ-006 SHALL have ports input_sec, input_min, input_hour, input_day, input_month  output  8 each, and input_year  output  16  values driven to the handlers' set inputs.
REQ-007 SHALL have ports set_time, set_date  output  1 each  single-cycle load strobes.
REQ-008 SHALL have ports editing  output  1  (high in any non-IDLE state) and edit_field  output  3  (0 none, 1 hour, 2 min, 3 sec, 4 day, 5 month, 6 year).

Function
REQ-009 SHALL implement states IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT_TIME, EDIT_DAY, EDIT_MONTH, EDIT_YEAR, COMMIT_DATE.
REQ-010 SHALL, on btn_mode in IDLE, copy all cur_* into shadow registers and enter EDIT_HOUR on the next edge.
REQ-011 SHALL advance on btn_next: HOUR->MIN->SEC->COMMIT_TIME; DAY->MONTH->YEAR->COMMIT_DATE.
REQ-012 SHALL hold COMMIT_TIME exactly one cycle with set_time=1, then enter EDIT_DAY; COMMIT_DATE one cycle with set_date=1, then IDLE.
REQ-013 SHALL, on btn_mode in any EDIT_* state, return to IDLE with no strobe (abort); a time already committed stays committed.
REQ-014 SHALL apply button priority mode > next > inc/dec; btn_inc and btn_dec together SHALL leave the field unchanged.
REQ-015 SHALL, on btn_inc/btn_dec, modify only the shadow of the active field, wrapping: hour 0..23, min/sec 0..59, month 1..12, year 2000..2099, day 1..D.
REQ-016 SHALL compute D from shadow month/year: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if (year%4==0 and year%100!=0) or year%400==0, else 28.
REQ-017 SHALL drive input_day = min(shadow_day, D), so a stale day (e.g. 31 after month changed to 4) is clamped at commit.
REQ-018 SHALL drive all other input_* directly from shadow registers, stable whenever a strobe is high.
REQ-019 SHALL keep set_time and set_date registered, never high simultaneously, and never high outside COMMIT states.
REQ-020 SHALL ignore btn_next/inc/dec in IDLE and all buttons in COMMIT states.

Reset
REQ-021 SHALL, while reset=0, force state IDLE, set_time=0, set_date=0, editing=0, edit_field=0, shadow hour/min/sec=0, day=1, month=1, year=2020, timeout counter=0.
REQ-022 SHALL, on reset asserted mid-edit or during a COMMIT state, abandon the edit immediately with no strobe.

Configuration
REQ-023 SHALL, with SET_TIMEOUT_EN defined, count cycles in EDIT_* states with no button pulse, clear on any pulse or on leaving edit, and return to IDLE without strobe when the count reaches TIMEOUT_CYCLES.
REQ-024 SHALL, without SET_TIMEOUT_EN, contain no timeout counter and remain in an edit state indefinitely.

Verification
REQ-025 SHALL cover: cur=13:45:10, mode, inc x2 (hour), next, dec (min), next, next -> one-cycle set_time with 15:44:10, then edit_field=4.
REQ-026 SHALL cover: date edit month=2, year=2023, day=29 shadow, commit -> set_date with input_day=28; year=2024 -> 29; year=2100 wrap -> 2000, day 29 kept.
REQ-027 SHALL cover: hour=23 inc -> 0; min=0 dec -> 59; month=12 inc -> 1; day=1 dec in April -> 30.
REQ-028 SHALL cover: mode in EDIT_MIN -> IDLE, set_time never asserted; mode+inc same cycle in EDIT_HOUR -> abort, hour unchanged.
REQ-029 SHALL cover: reset pulsed low during COMMIT_TIME -> set_time=0 that cycle onward, all outputs at reset values.
REQ-030 SHALL cover (SET_TIMEOUT_EN, TIMEOUT_CYCLES=30): no buttons for 30 cycles in EDIT_DAY -> IDLE with no set_date; a pulse at cycle 29 restarts the count.
